// File: rtl/bus_dev_pkg.sv
`default_nettype none
// ============================================================================
// bus_dev_pkg : shared constants and helpers for the device FIFO bank
// Rev 1.0
// ============================================================================
package bus_dev_pkg;

  localparam int ADDR_W    = 8;
  localparam int PKT_W_MAX = 512;

  // Bit positions inside the sticky per-device error nibble
  localparam int ERR_TX_UDF = 0;
  localparam int ERR_TX_OVF = 1;
  localparam int ERR_RX_UDF = 2;
  localparam int ERR_RX_OVF = 3;
  localparam int ERR_W      = 4;

  typedef logic [ADDR_W-1:0] dev_id_t;

  // Packets arrive zero-extended to PKT_W_MAX; pkt_w is the real packet width
  function automatic dev_id_t dest_of(input logic [PKT_W_MAX-1:0] pkt, input int pkt_w);
    return pkt[pkt_w-1 -: ADDR_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_dev_fifo.sv
`default_nettype none
// ============================================================================
// bus_dev_fifo : show-ahead FIFO with occupancy count and ovf/udf pulses
// Rev 1.0
// ============================================================================
module bus_dev_fifo #(
  parameter  int W     = 16,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_wr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_rd,
  output logic [W-1:0]  o_rdata,
  output logic [CW-1:0] o_count,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_ovf,
  output logic          o_udf
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_full;
  logic          r_empty;
  logic          w_wr_ok;
  logic          w_rd_ok;
  logic [CW-1:0] w_count_nxt;

  // A read frees a slot in the same edge, so a full FIFO still accepts wr+rd
  assign w_rd_ok = i_rd && !r_empty;
  assign w_wr_ok = i_wr && (!r_full || w_rd_ok);

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr_ok && !w_rd_ok) begin
      w_count_nxt = r_count + 1'b1;
    end else if (!w_wr_ok && w_rd_ok) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_wr_ok) r_wptr <= r_wptr + 1'b1;
      if (w_rd_ok) r_rptr <= r_rptr + 1'b1;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
      r_empty <= (w_count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset && w_wr_ok) r_mem[r_wptr] <= i_wdata;
  end

  assign o_rdata = r_empty ? '0 : r_mem[r_rptr];
  assign o_count = r_count;
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_ovf   = i_wr && !w_wr_ok;
  assign o_udf   = i_rd && !w_rd_ok;

endmodule
`default_nettype wire

// File: rtl/bus_dev_fifo_bank.sv
`default_nettype none
// ============================================================================
// bus_dev_fifo_bank : per-device TX/RX FIFO pair with RX address filter
// Rev 1.0
// ============================================================================
module bus_dev_fifo_bank
  import bus_dev_pkg::*;
#(
  parameter  int         drvrs     = 4,
  parameter  int         pckg_sz   = 16,
  parameter  int         depth     = 8,
  parameter  logic [7:0] broadcast = 8'hFF,
  parameter  bit         filter_en = 1'b1,
  localparam int         CW        = $clog2(depth + 1)
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [drvrs-1:0]                 wr_en,
  input  logic [drvrs-1:0][pckg_sz-1:0]    wr_data,
  output logic [drvrs-1:0]                 tx_full,
  output logic [drvrs-1:0][CW-1:0]         tx_count,
  output logic [drvrs-1:0]                 pndng,
  output logic [drvrs-1:0][pckg_sz-1:0]    D_pop,
  input  logic [drvrs-1:0]                 pop,
  input  logic [drvrs-1:0]                 push,
  input  logic [drvrs-1:0][pckg_sz-1:0]    D_push,
  output logic [drvrs-1:0]                 rx_valid,
  output logic [drvrs-1:0][pckg_sz-1:0]    rd_data,
  input  logic [drvrs-1:0]                 rd_en,
  output logic [drvrs-1:0][CW-1:0]         rx_count,
  output logic [drvrs-1:0]                 rx_drop,
  output logic [drvrs-1:0][ERR_W-1:0]      err,
  input  logic [drvrs-1:0]                 clr_err
);

  for (genvar i = 0; i < drvrs; i++) begin : g_dev
    logic             w_tx_empty;
    logic             w_tx_ovf;
    logic             w_tx_udf;
    logic             w_rx_empty;
    logic             w_rx_full_unused;
    logic             w_rx_ovf;
    logic             w_rx_udf;
    dev_id_t          w_dest;
    logic             w_accept;
    logic [ERR_W-1:0] w_err_set;
    logic [ERR_W-1:0] r_err;
    logic             r_rx_drop;

    assign w_dest   = dest_of(PKT_W_MAX'(D_push[i]), pckg_sz);
    assign w_accept = !filter_en || (w_dest == dev_id_t'(i)) || (w_dest == broadcast);

    bus_dev_fifo #(.W(pckg_sz), .DEPTH(depth)) u_tx (
      .clk     (clk),
      .reset   (reset),
      .i_wr    (wr_en[i]),
      .i_wdata (wr_data[i]),
      .i_rd    (pop[i]),
      .o_rdata (D_pop[i]),
      .o_count (tx_count[i]),
      .o_full  (tx_full[i]),
      .o_empty (w_tx_empty),
      .o_ovf   (w_tx_ovf),
      .o_udf   (w_tx_udf)
    );

    bus_dev_fifo #(.W(pckg_sz), .DEPTH(depth)) u_rx (
      .clk     (clk),
      .reset   (reset),
      .i_wr    (push[i] && w_accept),
      .i_wdata (D_push[i]),
      .i_rd    (rd_en[i]),
      .o_rdata (rd_data[i]),
      .o_count (rx_count[i]),
      .o_full  (w_rx_full_unused),
      .o_empty (w_rx_empty),
      .o_ovf   (w_rx_ovf),
      .o_udf   (w_rx_udf)
    );

    always_comb begin
      w_err_set             = '0;
      w_err_set[ERR_TX_UDF] = w_tx_udf;
      w_err_set[ERR_TX_OVF] = w_tx_ovf;
      w_err_set[ERR_RX_UDF] = w_rx_udf;
      w_err_set[ERR_RX_OVF] = w_rx_ovf;
    end

    // A new error event in the clearing cycle survives the clear
    always_ff @(posedge clk) begin
      if (!reset) begin
        r_err     <= '0;
        r_rx_drop <= 1'b0;
      end else begin
        r_err     <= (clr_err[i] ? '0 : r_err) | w_err_set;
        r_rx_drop <= push[i] && !w_accept;
      end
    end

    assign pndng[i]    = !w_tx_empty;
    assign rx_valid[i] = !w_rx_empty;
    assign err[i]      = r_err;
    assign rx_drop[i]  = r_rx_drop;
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_dev_fifo_bank.sv
`default_nettype none
// ============================================================================
// tb_bus_dev_fifo_bank : directed and randomised checks of the FIFO bank
// Rev 1.0
// ============================================================================
module tb_bus_dev_fifo_bank;

  localparam int N  = 4;
  localparam int PW = 16;
  localparam int D  = 4;
  localparam int CW = $clog2(D + 1);

  logic                  clk = 1'b0;
  logic                  reset;
  logic [N-1:0]          wr_en, pop, push, rd_en, clr_err;
  logic [N-1:0][PW-1:0]  wr_data, D_push;
  logic [N-1:0]          tx_full, pndng, rx_valid, rx_drop;
  logic [N-1:0][CW-1:0]  tx_count, rx_count;
  logic [N-1:0][PW-1:0]  D_pop, rd_data;
  logic [N-1:0][3:0]     err;

  int n_chk  = 0;
  int n_fail = 0;

  logic [PW-1:0] txq [N][$];
  logic [PW-1:0] rxq [N][$];
  logic [3:0]    m_err  [N];
  logic          m_drop [N];

  bus_dev_fifo_bank #(.drvrs(N), .pckg_sz(PW), .depth(D), .broadcast(8'hFF), .filter_en(1'b1)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .tx_full(tx_full),
    .tx_count(tx_count), .pndng(pndng), .D_pop(D_pop), .pop(pop), .push(push),
    .D_push(D_push), .rx_valid(rx_valid), .rd_data(rd_data), .rd_en(rd_en),
    .rx_count(rx_count), .rx_drop(rx_drop), .err(err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = '0; pop = '0; push = '0; rd_en = '0; clr_err = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    wr_en = '1; push = '1; pop = '1; rd_en = '1;
    for (int i = 0; i < N; i++) begin
      wr_data[i] = 16'hDEAD;
      D_push[i]  = 16'hFFEE;
    end
    repeat (3) tick();
    reset = 1'b1;
    idle();
  endtask

  initial begin
    logic [PW-1:0] exp_d1 [4];
    reset = 1'b1;
    idle();
    wr_data = '0;
    D_push  = '0;
    @(posedge clk);
    #1;

    // 1: reset with traffic active
    do_reset();
    chk("rst_tx_count", tx_count, 0);
    chk("rst_rx_count", rx_count, 0);
    chk("rst_pndng", pndng, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_tx_full", tx_full, 0);
    chk("rst_err", err, 0);
    chk("rst_rx_drop", rx_drop, 0);
    chk("rst_dpop", D_pop, 0);

    // 2: TX ordering on dev0
    wr_en[0] = 1'b1; wr_data[0] = 16'h0101;
    tick();
    chk("tx_pndng_lat1", pndng[0], 1);
    chk("tx_head_a", D_pop[0], 16'h0101);
    wr_data[0] = 16'h0102;
    tick();
    wr_en[0] = 1'b0;
    chk("tx_count2", tx_count[0], 2);
    pop[0] = 1'b1;
    tick();
    chk("tx_head_b", D_pop[0], 16'h0102);
    chk("tx_count1", tx_count[0], 1);
    tick();
    pop[0] = 1'b0;
    chk("tx_pndng_empty", pndng[0], 0);
    chk("tx_dpop_empty", D_pop[0], 0);
    chk("tx_err0", err[0], 0);

    // 3: TX full on dev1
    wr_en[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wr_data[1] = 16'h1100 + 16'(k);
      tick();
    end
    chk("full_flag", tx_full[1], 1);
    chk("full_count", tx_count[1], 4);
    chk("full_err_none", err[1], 0);
    wr_data[1] = 16'h1104;
    tick();
    wr_en[1] = 1'b0;
    chk("ovf_err", err[1], 4'b0010);
    chk("ovf_count", tx_count[1], 4);
    clr_err[1] = 1'b1;
    tick();
    clr_err[1] = 1'b0;
    chk("ovf_clr", err[1], 0);
    wr_en[1] = 1'b1; pop[1] = 1'b1; wr_data[1] = 16'h11AA;
    tick();
    wr_en[1] = 1'b0; pop[1] = 1'b0;
    chk("fullwp_count", tx_count[1], 4);
    chk("fullwp_full", tx_full[1], 1);
    chk("fullwp_err", err[1], 0);
    exp_d1 = '{16'h1101, 16'h1102, 16'h1103, 16'h11AA};
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain1_%0d", k), D_pop[1], exp_d1[k]);
      pop[1] = 1'b1;
      tick();
      pop[1] = 1'b0;
    end
    chk("drain1_empty", pndng[1], 0);

    // 4: RX address filter on dev2
    push[2] = 1'b1; D_push[2] = 16'h0255;
    tick();
    chk("rx_own_valid", rx_valid[2], 1);
    chk("rx_own_data", rd_data[2], 16'h0255);
    D_push[2] = 16'h0355;
    tick();
    chk("rx_drop_pulse", rx_drop[2], 1);
    chk("rx_drop_count", rx_count[2], 1);
    D_push[2] = 16'hFF77;
    tick();
    push[2] = 1'b0;
    chk("rx_drop_end", rx_drop[2], 0);
    chk("rx_bcast_count", rx_count[2], 2);
    rd_en[2] = 1'b1;
    tick();
    chk("rx_bcast_data", rd_data[2], 16'hFF77);
    tick();
    rd_en[2] = 1'b0;
    chk("rx_empty", rx_valid[2], 0);
    chk("rx_empty_data", rd_data[2], 0);
    chk("rx_err2", err[2], 0);

    // 5: underflow and clear priority on dev3
    rd_en[3] = 1'b1; pop[3] = 1'b1;
    tick();
    idle();
    chk("udf_err", err[3], 4'b0101);
    clr_err[3] = 1'b1;
    tick();
    chk("udf_clr", err[3], 0);
    pop[3] = 1'b1;
    tick();
    idle();
    chk("clr_set_wins", err[3], 4'b0001);
    clr_err[3] = 1'b1;
    tick();
    clr_err[3] = 1'b0;
    chk("clr_again", err[3], 0);

    // 6: pointer wrap on dev0
    for (int k = 0; k < 10; k++) begin
      wr_en[0] = 1'b1; wr_data[0] = 16'hA000 + 16'(k);
      tick();
      wr_en[0] = 1'b0;
      chk($sformatf("wrap_head_%0d", k), D_pop[0], 16'hA000 + 16'(k));
      pop[0] = 1'b1;
      tick();
      pop[0] = 1'b0;
      chk($sformatf("wrap_cnt_%0d", k), tx_count[0], 0);
    end
    chk("wrap_err", err[0], 0);

    // 7: random traffic against a queue model
    do_reset();
    for (int c = 0; c < N; c++) begin
      txq[c].delete();
      rxq[c].delete();
      m_err[c]  = '0;
      m_drop[c] = 1'b0;
    end
    for (int cyc = 0; cyc < 5000; cyc++) begin
      for (int c = 0; c < N; c++) begin
        logic [7:0] dst;
        logic       t_rd, t_wr, r_rd, r_wr, acc;
        logic [3:0] set;
        wr_en[c]   = 1'($urandom_range(0, 1));
        pop[c]     = 1'($urandom_range(0, 1));
        push[c]    = 1'($urandom_range(0, 1));
        rd_en[c]   = 1'($urandom_range(0, 1));
        clr_err[c] = ($urandom_range(0, 15) == 0);
        wr_data[c] = 16'($urandom);
        case ($urandom_range(0, 5))
          4:       dst = 8'hFF;
          5:       dst = 8'h10;
          default: dst = 8'($urandom_range(0, 3));
        endcase
        D_push[c] = {dst, 8'($urandom)};
        acc  = (dst == 8'(c)) || (dst == 8'hFF);
        t_rd = pop[c] && (txq[c].size() > 0);
        t_wr = wr_en[c] && ((txq[c].size() < D) || t_rd);
        r_rd = rd_en[c] && (rxq[c].size() > 0);
        r_wr = push[c] && acc && ((rxq[c].size() < D) || r_rd);
        set  = {push[c] && acc && !r_wr, rd_en[c] && !r_rd, wr_en[c] && !t_wr, pop[c] && !t_rd};
        if (t_rd) void'(txq[c].pop_front());
        if (t_wr) txq[c].push_back(wr_data[c]);
        if (r_rd) void'(rxq[c].pop_front());
        if (r_wr) rxq[c].push_back(D_push[c]);
        m_err[c]  = (clr_err[c] ? 4'b0 : m_err[c]) | set;
        m_drop[c] = push[c] && !acc;
      end
      tick();
      for (int c = 0; c < N; c++) begin
        chk($sformatf("r%0d_c%0d_txcnt", cyc, c), tx_count[c], txq[c].size());
        chk($sformatf("r%0d_c%0d_dpop", cyc, c), D_pop[c], txq[c].size() > 0 ? txq[c][0] : 16'h0);
        chk($sformatf("r%0d_c%0d_pndng", cyc, c), pndng[c], txq[c].size() > 0);
        chk($sformatf("r%0d_c%0d_full", cyc, c), tx_full[c], txq[c].size() == D);
        chk($sformatf("r%0d_c%0d_rxcnt", cyc, c), rx_count[c], rxq[c].size());
        chk($sformatf("r%0d_c%0d_rdata", cyc, c), rd_data[c], rxq[c].size() > 0 ? rxq[c][0] : 16'h0);
        chk($sformatf("r%0d_c%0d_err", cyc, c), err[c], m_err[c]);
        chk($sformatf("r%0d_c%0d_drop", cyc, c), rx_drop[c], m_drop[c]);
      end
    end
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
